// File: rtl/legv8_fetch_unit.sv
// rtl/legv8_fetch_unit.sv - LEGv8 instruction fetch stage with req/ack memory port and valid/ready output
module legv8_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Word alignment mask: instruction addresses never carry byte offset bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              capture;

  // State and next-fetch address registers; reset aborts any outstanding request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Next-state, next-fetch-address and decoded outputs from the registered state.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    capture       = 1'b0;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    imem_addr     = fetch_pc & ALIGN_MASK;
    case (state)
      IDLE: begin
        // Any ack seen here belongs to a request cancelled by reset.
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture       = 1'b1;
          fetch_pc_next = fetch_pc + PC_INC;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = REQ;
          // Redirect only once the current word has been consumed.
          if (branch_en) begin
            fetch_pc_next = branch_target & ALIGN_MASK;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Instruction register and its address, loaded on the accepted memory response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction <= 32'h0;
      pc          <= RESET_PC;
    end else if (capture) begin
      instruction <= imem_rdata;
      pc          <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// tb/tb_legv8_fetch_unit.sv - directed table-driven bench for legv8_fetch_unit
`timescale 1ns/1ps
module tb_legv8_fetch_unit;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [63:0] tgt;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        branch_en;
  logic [63:0] branch_target;

  logic        imem_req,    imem_req2;
  logic [63:0] imem_addr,   imem_addr2;
  logic [31:0] instruction, instruction2;
  logic        instr_valid, instr_valid2;
  logic [63:0] pc,          pc2;

  int total;
  int bad;

  localparam logic [31:0] D0 = 32'h8B1F0040;
  localparam logic [31:0] D1 = 32'hF84003E1;
  localparam logic [31:0] D2 = 32'h91000421;
  localparam logic [31:0] D3 = 32'hB4000040;
  localparam logic [31:0] D4 = 32'hD65F03C0;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  legv8_fetch_unit #(.ADDR_W(64)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc),
    .branch_en(branch_en), .branch_target(branch_target)
  );

  legv8_fetch_unit #(.ADDR_W(64), .RESET_PC(TOP_PC)) dut_top (
    .clock(clock), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready), .pc(pc2),
    .branch_en(branch_en), .branch_target(branch_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [63:0] addr,
                               input logic valid, input logic [31:0] instr, input logic [63:0] pcv);
    check({tag, ".imem_req"},    {63'd0, imem_req},    {63'd0, req});
    check({tag, ".imem_addr"},   imem_addr,            addr);
    check({tag, ".instr_valid"}, {63'd0, instr_valid}, {63'd0, valid});
    check({tag, ".instruction"}, {32'd0, instruction}, {32'd0, instr});
    check({tag, ".pc"},          pc,                   pcv);
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic br, input logic [63:0] tgt, input logic req,
                              input logic [63:0] addr, input logic valid,
                              input logic [31:0] instr, input logic [63:0] pcv);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc = pcv;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    total = 0;
    bad   = 0;

    //            ack  rdata ready br  tgt       req  addr      valid instr pc
    tbl[0]  = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 32'h0, 64'h0);   // IDLE
    tbl[1]  = mk(1'b1, D0,   1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   1'b0, 32'h0, 64'h0);   // REQ, ack
    tbl[2]  = mk(1'b0, JUNK, 1'b1, 1'b0, 64'h0,   1'b0, 64'h4,   1'b1, D0,    64'h0);   // HOLD, consume
    tbl[3]  = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   1'b0, D0,    64'h0);   // REQ wait 1
    tbl[4]  = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   1'b0, D0,    64'h0);   // REQ wait 2
    tbl[5]  = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   1'b0, D0,    64'h0);   // REQ wait 3
    tbl[6]  = mk(1'b1, D1,   1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   1'b0, D0,    64'h0);   // REQ, ack on 4th
    tbl[7]  = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b0, 64'h8,   1'b1, D1,    64'h4);   // HOLD stall 1
    tbl[8]  = mk(1'b1, JUNK, 1'b0, 1'b0, 64'h0,   1'b0, 64'h8,   1'b1, D1,    64'h4);   // stray ack ignored
    tbl[9]  = mk(1'b0, JUNK, 1'b0, 1'b1, 64'h200, 1'b0, 64'h8,   1'b1, D1,    64'h4);   // branch w/o ready
    tbl[10] = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b0, 64'h8,   1'b1, D1,    64'h4);   // HOLD stall 4
    tbl[11] = mk(1'b0, JUNK, 1'b1, 1'b0, 64'h0,   1'b0, 64'h8,   1'b1, D1,    64'h4);   // consume
    tbl[12] = mk(1'b1, D2,   1'b0, 1'b0, 64'h0,   1'b1, 64'h8,   1'b0, D1,    64'h4);   // REQ addr 8
    tbl[13] = mk(1'b0, JUNK, 1'b0, 1'b1, 64'h103, 1'b0, 64'hC,   1'b1, D2,    64'h8);   // branch, not ready
    tbl[14] = mk(1'b0, JUNK, 1'b1, 1'b1, 64'h103, 1'b0, 64'hC,   1'b1, D2,    64'h8);   // branch taken
    tbl[15] = mk(1'b1, D3,   1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 1'b0, D2,    64'h8);   // REQ at target
    tbl[16] = mk(1'b0, JUNK, 1'b1, 1'b0, 64'h0,   1'b0, 64'h104, 1'b1, D3,    64'h100); // HOLD
    tbl[17] = mk(1'b0, JUNK, 1'b0, 1'b0, 64'h0,   1'b1, 64'h104, 1'b0, D3,    64'h100); // REQ

    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch_en = 1'b0;
    branch_target = 64'h0;

    #1;
    check_outputs("reset", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    check("reset.top_addr", imem_addr2, TOP_PC);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      imem_ack      = tbl[i].ack;
      imem_rdata    = tbl[i].rdata;
      instr_ready   = tbl[i].ready;
      branch_en     = tbl[i].br;
      branch_target = tbl[i].tgt;
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                    tbl[i].instr, tbl[i].pc);
      if (i == 1) begin
        check("top.req_addr", imem_addr2, TOP_PC);
      end
      if (i == 2) begin
        check("top.pc", pc2, TOP_PC);
        check("top.wrap_addr", imem_addr2, 64'h0);
        check("top.instruction", {32'd0, instruction2}, {32'd0, D0});
        check("top.valid", {63'd0, instr_valid2}, 64'd1);
      end
      if (i == 3) begin
        check("top.wrap_req", {63'd0, imem_req2}, 64'd1);
        check("top.wrap_req_addr", imem_addr2, 64'h0);
      end
      @(negedge clock);
    end

    // Reset asserted mid-REQ while an ack is arriving: takes effect at once.
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = JUNK;
    #1;
    check_outputs("rst_async", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    check_outputs("rst_held", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    // Release with the late ack still present: it lands in IDLE and is dropped.
    reset = 1'b0;
    #1;
    check_outputs("rst_idle", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    imem_ack = 1'b0;
    #1;
    check_outputs("rst_req", 1'b1, 64'h0, 1'b0, 32'h0, 64'h0);
    check("rst_req.top_addr", imem_addr2, TOP_PC);
    @(negedge clock);
    imem_ack = 1'b1;
    imem_rdata = D4;
    #1;
    check_outputs("rst_req2", 1'b1, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    imem_ack = 1'b0;
    #1;
    check_outputs("rst_hold", 1'b0, 64'h4, 1'b1, D4, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
